// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared definitions for the program loader.
//   - Bus widths for the ROM write port (byte address and data word).
//   - Full-word byte-select constant.
//   - Loader state encoding (LD_CHK is used only when ROM_LOADER_CHKSUM_EN is defined).
//   - range_fault(): true when a load would run past the end of the ROM.
package rom_loader_pkg;

    localparam int          ADDR_W   = 32;
    localparam int          WORD_W   = 32;
    localparam logic [3:0]  FULL_SEL = 4'b1111;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_RECV  = 3'd1,
        LD_WRITE = 3'd2,
        LD_DONE  = 3'd3,
        LD_CHK   = 3'd4
    } ld_state_t;

    // Word-granular end-of-load check; 33-bit sum so a large base cannot wrap.
    function automatic logic range_fault(input logic [29:0] base_word,
                                         input logic [31:0] cnt,
                                         input logic [31:0] depth);
        logic [32:0] end_word;
        end_word = {3'b000, base_word} + {1'b0, cnt};
        return (end_word > {1'b0, depth});
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: byte-stream input and ROM write port of the program loader.
//   rx_valid_i / rx_data_i / rx_ready_o : byte stream handshake
//   w_en_o / w_addr_o / w_data_o / w_sel_o : ROM write port
// The slave modport is the loader's view (it consumes the stream and drives
// the ROM port); the master modport is the environment's view.
interface rom_loader_if;
    import rom_loader_pkg::*;

    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              rx_ready_o;
    logic              w_en_o;
    logic [ADDR_W-1:0] w_addr_o;
    logic [WORD_W-1:0] w_data_o;
    logic [3:0]        w_sel_o;

    modport master (
        output rx_valid_i, rx_data_i,
        input  rx_ready_o, w_en_o, w_addr_o, w_data_o, w_sel_o
    );

    modport slave (
        input  rx_valid_i, rx_data_i,
        output rx_ready_o, w_en_o, w_addr_o, w_data_o, w_sel_o
    );

endinterface

// File: rtl/rom_loader_packer.sv
// rom_loader_packer: assembles four bytes into a little-endian 32-bit word.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : drops any partial word and restarts at byte 0
//   accept      : a byte transfers this cycle
//   byte_in     : the byte transferring this cycle
//   word_valid  : high in the cycle the fourth byte transfers
//   word        : completed word, valid while word_valid is high
module rom_loader_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx_r;
    logic [23:0] part_r;

    // Shift each byte in from the top so the first byte ends at bits [7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_r <= 2'd0;
            part_r     <= 24'h00_0000;
        end else if (clear) begin
            byte_idx_r <= 2'd0;
            part_r     <= 24'h00_0000;
        end else if (accept) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            part_r     <= {byte_in, part_r[23:8]};
        end
    end

    // The fourth byte is not stored; the word is completed on the fly.
    assign word_valid = accept && (byte_idx_r == 2'd3);
    assign word       = {byte_in, part_r};

endmodule

// File: rtl/rom_loader.sv
// rom_loader: loads a byte stream into the instruction ROM as 32-bit words,
// holding the core in reset for the duration of the load.
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : load request, sampled only while idle
//   base_addr_i     : byte address of first word (bits [1:0] ignored)
//   word_cnt_i      : number of words to load
//   bus (slave)     : byte stream in, ROM write port out
//   busy_o          : load in progress (start accepted until done)
//   cpu_hold_o      : copy of busy_o, keeps the core in reset
//   done_o          : one-cycle completion pulse
//   err_o           : sticky error (range fault, or checksum mismatch)
// Optional: define ROM_LOADER_CHKSUM_EN to require a trailing byte equal to
// the 8-bit modular sum of the payload.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ROM_DEPTH = 16384,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  word_cnt_i,
    rom_loader_if.slave       bus,
    output logic              busy_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);

    ld_state_t         state_r;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  word_idx_r;
    logic              rx_ready_r;
    logic              w_en_r;
    logic [ADDR_W-1:0] w_addr_r;
    logic [WORD_W-1:0] w_data_r;
    logic [3:0]        w_sel_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              clear_s;
    logic              accept_s;
    logic              fault_s;
    logic              last_word_s;
    logic              word_valid_s;
    logic [WORD_W-1:0] word_s;

`ifdef ROM_LOADER_CHKSUM_EN
    logic [7:0]        sum_r;
    logic              chk_accept_s;
    assign chk_accept_s = (state_r == LD_CHK) && bus.rx_valid_i && rx_ready_r;
`endif

    assign clear_s     = (state_r == LD_IDLE) && start_i;
    assign accept_s    = (state_r == LD_RECV) && bus.rx_valid_i && rx_ready_r;
    assign fault_s     = range_fault(base_addr_i[31:2], 32'(word_cnt_i), 32'(ROM_DEPTH));
    assign last_word_s = ((word_idx_r + CNT_W'(1)) == cnt_r);

    rom_loader_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_s),
        .accept     (accept_s),
        .byte_in    (bus.rx_data_i),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Load sequencer; every output is registered and set on the edge entering its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= LD_IDLE;
            base_r     <= 32'h0000_0000;
            cnt_r      <= {CNT_W{1'b0}};
            word_idx_r <= {CNT_W{1'b0}};
            rx_ready_r <= 1'b0;
            w_en_r     <= 1'b0;
            w_addr_r   <= 32'h0000_0000;
            w_data_r   <= 32'h0000_0000;
            w_sel_r    <= 4'b0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
`ifdef ROM_LOADER_CHKSUM_EN
            sum_r      <= 8'h00;
`endif
        end else begin
            case (state_r)
                LD_IDLE: begin
                    if (start_i) begin
                        base_r     <= base_addr_i & 32'hFFFF_FFFC;
                        cnt_r      <= word_cnt_i;
                        word_idx_r <= {CNT_W{1'b0}};
                        err_r      <= 1'b0;
`ifdef ROM_LOADER_CHKSUM_EN
                        sum_r      <= 8'h00;
`endif
                        if (fault_s) begin
                            err_r <= 1'b1;
                        end else if (word_cnt_i == {CNT_W{1'b0}}) begin
                            busy_r <= 1'b1;
`ifdef ROM_LOADER_CHKSUM_EN
                            rx_ready_r <= 1'b1;
                            state_r    <= LD_CHK;
`else
                            done_r  <= 1'b1;
                            state_r <= LD_DONE;
`endif
                        end else begin
                            busy_r     <= 1'b1;
                            rx_ready_r <= 1'b1;
                            state_r    <= LD_RECV;
                        end
                    end
                end
                LD_RECV: begin
`ifdef ROM_LOADER_CHKSUM_EN
                    if (accept_s) begin
                        sum_r <= sum_r + bus.rx_data_i;
                    end
`endif
                    if (word_valid_s) begin
                        rx_ready_r <= 1'b0;
                        w_en_r     <= 1'b1;
                        w_sel_r    <= FULL_SEL;
                        w_data_r   <= word_s;
                        w_addr_r   <= base_r + ADDR_W'({word_idx_r, 2'b00});
                        state_r    <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    w_en_r     <= 1'b0;
                    w_sel_r    <= 4'b0000;
                    word_idx_r <= word_idx_r + CNT_W'(1);
                    if (last_word_s) begin
`ifdef ROM_LOADER_CHKSUM_EN
                        rx_ready_r <= 1'b1;
                        state_r    <= LD_CHK;
`else
                        done_r  <= 1'b1;
                        state_r <= LD_DONE;
`endif
                    end else begin
                        rx_ready_r <= 1'b1;
                        state_r    <= LD_RECV;
                    end
                end
                LD_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= LD_IDLE;
                end
`ifdef ROM_LOADER_CHKSUM_EN
                LD_CHK: begin
                    if (chk_accept_s) begin
                        if (bus.rx_data_i != sum_r) begin
                            err_r <= 1'b1;
                        end
                        rx_ready_r <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= LD_DONE;
                    end
                end
`endif
                default: begin
                    // Unreachable encodings fall back to a quiet idle.
                    rx_ready_r <= 1'b0;
                    w_en_r     <= 1'b0;
                    w_sel_r    <= 4'b0000;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    state_r    <= LD_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready_o = rx_ready_r;
    assign bus.w_en_o     = w_en_r;
    assign bus.w_addr_o   = w_addr_r;
    assign bus.w_data_o   = w_data_r;
    assign bus.w_sel_o    = w_sel_r;
    assign busy_o         = busy_r;
    assign cpu_hold_o     = busy_r;
    assign done_o         = done_r;
    assign err_o          = err_r;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader.
// Stimulus pushes the expected ROM writes (derived from base, count and the
// payload bytes) into queues; a negedge monitor pops and compares every write
// the loader issues. Honours ROM_LOADER_CHKSUM_EN for the trailing sum byte.
module tb_rom_loader;

    localparam int DEPTH = 16384;
    localparam int CW    = 16;
`ifdef ROM_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] word_cnt_i;
    logic        busy_o, cpu_hold_o, done_o, err_o;

    rom_loader_if bus ();

    rom_loader #(.ROM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .word_cnt_i  (word_cnt_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .cpu_hold_o  (cpu_hold_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int done_exp = 0;
    int writes_seen = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  pay_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every ROM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.w_en_o === 1'b1) begin
            writes_seen++;
            check("w_sel_write", 32'(bus.w_sel_o), 32'hF);
            check("rx_ready_in_write", 32'(bus.rx_ready_o), 32'h0);
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write_addr", bus.w_addr_o, 32'hFFFF_FFFF);
            end else begin
                check("w_addr", bus.w_addr_o, exp_addr_q.pop_front());
                check("w_data", bus.w_data_o, exp_data_q.pop_front());
            end
        end else begin
            check("w_sel_idle", 32'(bus.w_sel_o), 32'h0);
        end
        check("cpu_hold_eq_busy", 32'(cpu_hold_o), 32'(busy_o));
        if (done_o === 1'b1) done_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] c);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = b; word_cnt_i = c;
        @(posedge clk); #1;
        start_i = 1'b0; base_addr_i = $urandom; word_cnt_i = 16'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        @(negedge clk);
        while (bus.rx_ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("handshake_wait_ok", 32'(n < 100), 32'h1);
        @(posedge clk); #1;
        if (gap > 0) begin
            bus.rx_valid_i = 1'b0;
            bus.rx_data_i  = 8'($urandom);
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_seen < done_exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_count", 32'(done_seen), 32'(done_exp));
    endtask

    // gap < 0 selects a random 0..3 cycle gap after every byte.
    task automatic run_load(input logic [31:0] b, input logic [15:0] c, input int gap,
                            input bit inject, input bit bad_sum);
        bit          fault;
        bit          exp_err;
        logic [7:0]  sum;
        logic [31:0] d;
        int          g;
        fault   = (longint'(b / 4) + longint'(c)) > longint'(DEPTH);
        exp_err = fault | (CHK_EN & bad_sum);
        sum     = 8'h00;
        if (!fault) begin
            for (int i = 0; i < int'(c); i++) begin
                d = 32'(pay_q[4*i]) + (32'(pay_q[4*i+1]) * 32'd256)
                  + (32'(pay_q[4*i+2]) * 32'd65536) + (32'(pay_q[4*i+3]) * 32'd16777216);
                exp_addr_q.push_back((b - (b % 4)) + 32'(4 * i));
                exp_data_q.push_back(d);
            end
            done_exp++;
        end
        do_start(b, c);
        if (fault) begin
            check("fault_err", 32'(err_o), 32'h1);
            for (int k = 0; k < 3; k++) begin
                check("fault_busy", 32'(busy_o), 32'h0);
                @(posedge clk); #1;
            end
            check("fault_err_sticky", 32'(err_o), 32'h1);
        end else begin
`ifndef ROM_LOADER_CHKSUM_EN
            if (c == 16'd0) begin
                check("cnt0_done_next_cycle", 32'(done_o), 32'h1);
            end
`endif
            for (int i = 0; i < 4 * int'(c); i++) begin
                if (inject && i == 2) begin
                    start_i = 1'b1; base_addr_i = b + 32'h0000_0400; word_cnt_i = c + 16'd1;
                end
                g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                sum = sum + pay_q[i];
                send_byte(pay_q[i], g);
                start_i = 1'b0;
            end
            if (CHK_EN) send_byte(bad_sum ? sum + 8'h01 : sum, 0);
            bus.rx_valid_i = 1'b0;
            wait_done(200);
            @(posedge clk); #1;
            check("busy_after_done", 32'(busy_o), 32'h0);
            check("err_after_load", 32'(err_o), 32'(exp_err));
            check("scoreboard_empty", 32'(exp_addr_q.size()), 32'h0);
        end
        pay_q.delete();
    endtask

    initial begin
        int w0;
        logic [31:0] rb;
        rst = 1'b1; start_i = 1'b0; base_addr_i = 32'h0; word_cnt_i = 16'h0;
        bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_rx_ready", 32'(bus.rx_ready_o), 32'h0);
        check("rst_w_en", 32'(bus.w_en_o), 32'h0);
        check("rst_w_addr", bus.w_addr_o, 32'h0);
        check("rst_w_data", bus.w_data_o, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_rx_ready", 32'(bus.rx_ready_o), 32'h0);

        // Basic load, then the same with 3-cycle gaps between bytes.
        pay_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(32'h0000_0100, 16'd2, 0, 1'b0, 1'b0);
        pay_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(32'h0000_0100, 16'd2, 3, 1'b0, 1'b0);

        // Boundaries: empty load, last ROM word, one past the end.
        pay_q.delete();
        run_load(32'h0000_0300, 16'd0, 0, 1'b0, 1'b0);
        fill_random(4);
        run_load(32'h0000_FFFC, 16'd1, 0, 1'b0, 1'b0);
        run_load(32'h0000_FFFC, 16'd2, 0, 1'b0, 1'b0);

        // Reset after six bytes of a two-word load: only the first word lands.
        fill_random(8);
        exp_addr_q.push_back(32'h0000_0500);
        exp_data_q.push_back({pay_q[3], pay_q[2], pay_q[1], pay_q[0]});
        w0 = writes_seen;
        do_start(32'h0000_0500, 16'd2);
        for (int i = 0; i < 6; i++) send_byte(pay_q[i], 0);
        bus.rx_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy_o), 32'h0);
        check("midrst_hold", 32'(cpu_hold_o), 32'h0);
        check("midrst_rx_ready", 32'(bus.rx_ready_o), 32'h0);
        check("midrst_w_addr", bus.w_addr_o, 32'h0);
        check("midrst_w_data", bus.w_data_o, 32'h0);
        check("midrst_one_write", 32'(writes_seen - w0), 32'h1);
        check("midrst_queue", 32'(exp_addr_q.size()), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        pay_q.delete();
        fill_random(8);
        run_load(32'h0000_0500, 16'd2, 0, 1'b0, 1'b0);

        // A second start during RECV must not move the addresses.
        fill_random(12);
        run_load(32'h0000_0800, 16'd3, 1, 1'b1, 1'b0);

`ifdef ROM_LOADER_CHKSUM_EN
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(32'h0000_0040, 16'd1, 0, 1'b0, 1'b0);
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(32'h0000_0040, 16'd1, 0, 1'b0, 1'b1);
`endif

        // Randomized loads, including unaligned bases and occasional range faults.
        for (int t = 0; t < 12; t++) begin
            rb = (t == 11) ? 32'h8000_0001 : ($urandom & 32'h0000_FFFF);
            if (t % 4 == 3) rb = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
            fill_random(16);
            run_load(rb, 16'($urandom_range(1, 4)), -1, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_busy", 32'(busy_o), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
